// File: rtl/mem_responder_if.sv
// Request/response bundle between a word-addressed requester and mem_responder.
interface mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic              en;
  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rvalid;
  logic              wack;
  logic              busy;
  logic              addr_err;

  modport master (
    output en, ren, wen, addr, din,
    input  dout, rvalid, wack, busy, addr_err
  );

  modport slave (
    input  en, ren, wen, addr, din,
    output dout, rvalid, wack, busy, addr_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time, fixed read latency,
// single-cycle write acknowledge and completion/error pulses.
module mem_responder #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8192,
  parameter int READ_LAT = 2
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]      CNT_LOAD = 3'(READ_LAT - 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] raddr_reg, raddr_next;
  logic [DATA_W-1:0] dout_reg;
  logic              rvalid_reg, rvalid_next;
  logic              wack_reg, wack_next;
  logic              addr_err_reg, addr_err_next;

  logic req_one, req_both, addr_ok, raddr_ok;
  logic acc_rd, acc_wr, rd_done;

  logic [DATA_W-1:0] mem [DEPTH];

  // Unsigned compare with one spare bit so DEPTH == 2**ADDR_W stays representable.
  assign req_one  = bus.en && (bus.ren ^ bus.wen);
  assign req_both = bus.en && bus.ren && bus.wen;
  assign addr_ok  = {1'b0, bus.addr} < DEPTH_L;
  assign raddr_ok = {1'b0, raddr_reg} < DEPTH_L;
  assign acc_rd   = (state_reg == IDLE) && req_one && bus.ren;
  assign acc_wr   = (state_reg == IDLE) && req_one && bus.wen;
  assign rd_done  = (state_reg == RD_WAIT) && (cnt_reg == 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (acc_rd) state_next = RD_WAIT;
      RD_WAIT: if (cnt_reg == 3'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next      = cnt_reg;
    raddr_next    = raddr_reg;
    rvalid_next   = 1'b0;
    wack_next     = 1'b0;
    addr_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (acc_rd) begin
          raddr_next    = bus.addr;
          cnt_next      = CNT_LOAD;
          addr_err_next = !addr_ok;
        end else if (acc_wr) begin
          wack_next     = 1'b1;
          addr_err_next = !addr_ok;
        end else if (req_both) begin
          addr_err_next = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_reg == 3'd0) begin
          rvalid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg      <= 3'd0;
      raddr_reg    <= '0;
      dout_reg     <= '0;
      rvalid_reg   <= 1'b0;
      wack_reg     <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      raddr_reg    <= raddr_next;
      rvalid_reg   <= rvalid_next;
      wack_reg     <= wack_next;
      addr_err_reg <= addr_err_next;
      if (rd_done) begin
        dout_reg <= raddr_ok ? mem[raddr_reg[IDX_W-1:0]] : '0;
      end
    end
  end

  // Array has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (acc_wr && addr_ok && !reset) begin
      mem[bus.addr[IDX_W-1:0]] <= bus.din;
    end
  end

  assign bus.dout     = dout_reg;
  assign bus.rvalid   = rvalid_reg;
  assign bus.wack     = wack_reg;
  assign bus.addr_err = addr_err_reg;
  assign bus.busy     = (state_reg == RD_WAIT);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with hand-computed expectations.
module tb_mem_responder;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 8192;
  localparam int READ_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus.en  = 1'b0;
    bus.ren = 1'b0;
    bus.wen = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    bus.en = 1'b1; bus.wen = 1'b1; bus.ren = 1'b0; bus.addr = a; bus.din = d;
    tick;
    check("wr_wack", {31'b0, bus.wack}, 32'd1);
    idle_bus;
    $display("wr addr=0x%04h data=0x%08h", a, d);
    tick;
    check("wr_wack_clear", {31'b0, bus.wack}, 32'd0);
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d, output int lat);
    bus.en = 1'b1; bus.ren = 1'b1; bus.wen = 1'b0; bus.addr = a;
    tick;
    idle_bus;
    lat = 0;
    while (!bus.rvalid && lat < 16) begin
      tick;
      lat++;
    end
    if (!bus.rvalid) check("rd_timeout", 32'd0, 32'd1);
    d = bus.dout;
    $display("rd addr=0x%04h data=0x%08h lat=%0d", a, d, lat);
    tick;
  endtask

  logic [31:0] rdata;
  int          lat;
  logic [7:0]  acc_mask, rv_mask;
  logic        prev_busy, seen_rv;

  initial begin
    idle_bus;
    bus.addr = '0;
    bus.din  = '0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_dout", bus.dout, 32'd0);
    check("rst_flags", {28'b0, bus.rvalid, bus.wack, bus.busy, bus.addr_err}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("idle_quiet", {28'b0, bus.rvalid, bus.wack, bus.busy, bus.addr_err}, 32'd0);
    end

    do_write(16'd5, 32'hDEADBEEF);
    do_write(16'd9, 32'h0000_0099);
    do_write(16'd0, 32'h1234_5678);
    do_write(16'h1FFF, 32'h1F1F_1F1F);

    // Read of addr 5 with cycle-by-cycle latency checks.
    bus.en = 1'b1; bus.ren = 1'b1; bus.addr = 16'd5;
    tick;
    check("rd_a0_busy", {31'b0, bus.busy}, 32'd1);
    check("rd_a0_rvalid", {31'b0, bus.rvalid}, 32'd0);
    idle_bus;
    tick;
    check("rd_a1_busy", {31'b0, bus.busy}, 32'd1);
    check("rd_a1_rvalid", {31'b0, bus.rvalid}, 32'd0);
    tick;
    check("rd_a2_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("rd_a2_busy", {31'b0, bus.busy}, 32'd0);
    check("rd_a2_dout", bus.dout, 32'hDEADBEEF);
    tick;
    check("rd_a3_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("rd_a3_hold", bus.dout, 32'hDEADBEEF);
    $display("rd addr=0x0005 data=0x%08h", bus.dout);

    // Held read request: accepts at edges 1,4,7, completions at 3,6,9.
    acc_mask = '0; rv_mask = '0;
    bus.en = 1'b1; bus.ren = 1'b1; bus.addr = 16'd0;
    prev_busy = bus.busy;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.busy && !prev_busy) acc_mask[i] = 1'b1;
      if (bus.rvalid) begin
        rv_mask[i] = 1'b1;
        check("held_dout", bus.dout, 32'h1234_5678);
      end
      prev_busy = bus.busy;
    end
    idle_bus;
    check("held_accepts", {24'b0, acc_mask}, 32'h49);
    check("held_rvalids", {24'b0, rv_mask}, 32'h24);
    tick;
    check("held_last_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("held_last_dout", bus.dout, 32'h1234_5678);
    $display("held rd addr=0x0000 accepts=%b rvalids=%b", acc_mask, rv_mask);
    tick;

    // Write to 9 presented mid-read must be ignored.
    bus.en = 1'b1; bus.ren = 1'b1; bus.addr = 16'd5;
    tick;
    bus.ren = 1'b0; bus.wen = 1'b1; bus.addr = 16'd9; bus.din = 32'h0BAD_0BAD;
    tick;
    check("busy_wr_wack", {31'b0, bus.wack}, 32'd0);
    idle_bus;
    tick;
    check("busy_rd_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("busy_wr_nowack", {31'b0, bus.wack}, 32'd0);
    $display("busy rejection wr addr=0x0009 during rd");
    tick;
    do_read(16'd9, rdata, lat);
    check("busy_mem9", rdata, 32'h0000_0099);
    check("rd_latency", lat, READ_LAT);

    // Out-of-range read.
    bus.en = 1'b1; bus.ren = 1'b1; bus.addr = 16'(DEPTH);
    tick;
    check("oor_rd_err", {31'b0, bus.addr_err}, 32'd1);
    check("oor_rd_busy", {31'b0, bus.busy}, 32'd1);
    idle_bus;
    tick;
    check("oor_rd_err_clear", {31'b0, bus.addr_err}, 32'd0);
    tick;
    check("oor_rd_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("oor_rd_dout", bus.dout, 32'd0);
    $display("rd addr=0x%04h (out of range) data=0x%08h", 16'(DEPTH), bus.dout);
    tick;

    // Out-of-range write must not alias onto the low index bits.
    bus.en = 1'b1; bus.wen = 1'b1; bus.addr = 16'hFFFF; bus.din = 32'hCAFE_F00D;
    tick;
    check("oor_wr_err", {31'b0, bus.addr_err}, 32'd1);
    check("oor_wr_wack", {31'b0, bus.wack}, 32'd1);
    idle_bus;
    $display("wr addr=0xffff (out of range) dropped");
    tick;
    do_read(16'h1FFF, rdata, lat);
    check("oor_wr_noalias", rdata, 32'h1F1F_1F1F);

    // ren and wen both set: error, no action.
    bus.en = 1'b1; bus.ren = 1'b1; bus.wen = 1'b1; bus.addr = 16'd5; bus.din = 32'd0;
    tick;
    check("both_err", {31'b0, bus.addr_err}, 32'd1);
    check("both_quiet", {29'b0, bus.wack, bus.busy, bus.rvalid}, 32'd0);
    idle_bus;
    $display("ren+wen addr=0x0005 rejected");
    tick;
    check("both_err_clear", {31'b0, bus.addr_err}, 32'd0);
    do_read(16'd5, rdata, lat);
    check("both_nochange", rdata, 32'hDEADBEEF);

    // en with neither ren nor wen: nothing happens.
    bus.en = 1'b1; bus.addr = 16'd5;
    tick;
    check("none_quiet", {28'b0, bus.rvalid, bus.wack, bus.busy, bus.addr_err}, 32'd0);
    idle_bus;
    $display("en only addr=0x0005 no action");
    tick;

    // Reset in the middle of a read.
    bus.en = 1'b1; bus.ren = 1'b1; bus.addr = 16'd5;
    tick;
    idle_bus;
    #3 reset = 1'b1;
    #1;
    check("rstrd_busy", {31'b0, bus.busy}, 32'd0);
    check("rstrd_dout", bus.dout, 32'd0);
    tick;
    reset = 1'b0;
    seen_rv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (bus.rvalid) seen_rv = 1'b1;
    end
    check("rstrd_no_rvalid", {31'b0, seen_rv}, 32'd0);
    check("rstrd_dout_after", bus.dout, 32'd0);
    $display("reset during rd addr=0x0005 aborted");

    // Request held across reset release is accepted on the first edge.
    reset = 1'b1;
    bus.en = 1'b1; bus.ren = 1'b1; bus.addr = 16'd5;
    tick;
    reset = 1'b0;
    tick;
    check("rstrel_accept", {31'b0, bus.busy}, 32'd1);
    idle_bus;
    tick;
    tick;
    check("rstrel_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("rstrel_dout", bus.dout, 32'hDEADBEEF);
    $display("rd across reset release addr=0x0005 data=0x%08h", bus.dout);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
